// File: rtl/conv_share_arb_2ch_pkg.sv
// conv_arb_pkg: shared types and helpers for the two-channel convolution
// arbiter (conv_share_arb_2ch) and its tag FIFO.
package conv_arb_pkg;

   // Default float format: half precision (1 sign, 5 exponent, 10 fraction).
   localparam int DEF_EXP_WIDTH  = 5;
   localparam int DEF_FRAC_WIDTH = 10;
   localparam int DEF_FP_WIDTH   = 1 + DEF_EXP_WIDTH + DEF_FRAC_WIDTH;

   typedef logic [DEF_FP_WIDTH-1:0] fp_word_t;

   // Requester id. It is also the value stored in the tag FIFO.
   typedef enum logic {
      CH0 = 1'b0,
      CH1 = 1'b1
   } chan_t;

   // Width of an occupancy counter that has to hold the value 0..depth.
   function automatic int tag_cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/conv_share_arb_2ch_if.sv
// conv_share_arb_2ch_if: bundles the request, issue and return buses of
// conv_share_arb_2ch. The slave modport is the arbiter. The master modport
// is the environment: the requesters and the datapath.
interface conv_share_arb_2ch_if #(
   parameter int EXP_WIDTH     = 5,
   parameter int FRAC_WIDTH    = 10,
   parameter int WINDOW_WIDTH  = 1,
   parameter int WINDOW_HEIGHT = 3
);
   localparam int FPW = 1 + EXP_WIDTH + FRAC_WIDTH;

   logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FPW-1:0] ch0_window_i, ch1_window_i;
   logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FPW-1:0] kernel0_i, kernel1_i;
   logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FPW-1:0] conv_window_o, conv_kernel_o;
   logic [15:0]    ch0_col_i, ch0_row_i, ch1_col_i, ch1_row_i;
   logic           ch0_valid_i, ch1_valid_i, ch0_ready_o, ch1_ready_o;
   logic [15:0]    conv_col_o, conv_row_o;
   logic           conv_valid_o;
   logic [FPW-1:0] conv_data_i;
   logic [15:0]    conv_col_i, conv_row_i;
   logic           conv_valid_i;
   logic [FPW-1:0] ch0_data_o, ch1_data_o;
   logic [15:0]    ch0_col_o, ch0_row_o, ch1_col_o, ch1_row_o;
   logic           ch0_valid_o, ch1_valid_o;

   modport slave (
      input  ch0_window_i, ch1_window_i, kernel0_i, kernel1_i,
      input  ch0_col_i, ch0_row_i, ch1_col_i, ch1_row_i, ch0_valid_i, ch1_valid_i,
      output ch0_ready_o, ch1_ready_o,
      output conv_window_o, conv_kernel_o, conv_col_o, conv_row_o, conv_valid_o,
      input  conv_data_i, conv_col_i, conv_row_i, conv_valid_i,
      output ch0_data_o, ch0_col_o, ch0_row_o, ch0_valid_o,
      output ch1_data_o, ch1_col_o, ch1_row_o, ch1_valid_o
   );

   modport master (
      output ch0_window_i, ch1_window_i, kernel0_i, kernel1_i,
      output ch0_col_i, ch0_row_i, ch1_col_i, ch1_row_i, ch0_valid_i, ch1_valid_i,
      input  ch0_ready_o, ch1_ready_o,
      input  conv_window_o, conv_kernel_o, conv_col_o, conv_row_o, conv_valid_o,
      output conv_data_i, conv_col_i, conv_row_i, conv_valid_i,
      input  ch0_data_o, ch0_col_o, ch0_row_o, ch0_valid_o,
      input  ch1_data_o, ch1_col_o, ch1_row_o, ch1_valid_o
   );
endinterface

// File: rtl/conv_share_arb_2ch_tag_fifo.sv
// conv_arb_tag_fifo: small in-order FIFO. It records which channel owns
// each request that is still in flight in the shared datapath.
// dout_o shows the head entry without a read latency.
module conv_arb_tag_fifo
   import conv_arb_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int W     = 1,
   localparam int CW    = tag_cnt_width(DEPTH),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Full and empty come from the registered count.
   // A pop therefore does not free a slot for a push in the same cycle.
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Next-state logic for the pointers and the count. The pointers wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers. Reset discards every entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage. Storage is not reset, because the count marks which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/conv_share_arb_2ch.sv
// conv_share_arb_2ch: shares one convolution datapath between two window
// requesters. Arbitration is round-robin. A tag FIFO returns each result to
// the channel that issued it.
// Optional build macro CONV_SHARE_ARB_PERF_EN adds three counters:
// transfers per channel, and stall cycles caused by a full FIFO.
module conv_share_arb_2ch
   import conv_arb_pkg::*;
#(
   parameter  int EXP_WIDTH     = DEF_EXP_WIDTH,
   parameter  int FRAC_WIDTH    = DEF_FRAC_WIDTH,
   parameter  int WINDOW_WIDTH  = 1,
   parameter  int WINDOW_HEIGHT = 3,
   parameter  int TAG_DEPTH     = 16,
   localparam int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
   localparam int CNT_W         = tag_cnt_width(TAG_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   conv_share_arb_2ch_if.slave  bus,
   output logic                 err_o,
   output logic [CNT_W-1:0]     tag_count_o
`ifdef CONV_SHARE_ARB_PERF_EN
   ,
   output logic [31:0]          perf_grant0_o,
   output logic [31:0]          perf_grant1_o,
   output logic [31:0]          perf_stall_o
`endif
);
   typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

   chan_t                   last_grant_q, gnt_ch, tag_ch;
   logic                    gnt_any, xfer, pop;
   logic                    fifo_full, fifo_empty;
   logic [0:0]              tag_din, tag_dout;
   win_t                    win_d, kern_d, win_q, kern_q;
   logic [15:0]             col_d, row_d, col_q, row_q;
   logic                    conv_valid_q;
   logic                    ch0_valid_q, ch1_valid_q, err_q;
   logic [FP_WIDTH_REG-1:0] ch0_data_q, ch1_data_q;
   logic [15:0]             ch0_col_q, ch0_row_q, ch1_col_q, ch1_row_q;

   // Round-robin grant and issue mux. After reset last_grant is CH1,
   // so ch0 wins the first contention.
   always_comb begin
      gnt_any = bus.ch0_valid_i | bus.ch1_valid_i;
      gnt_ch  = CH0;
      if (bus.ch0_valid_i && bus.ch1_valid_i) gnt_ch = (last_grant_q == CH0) ? CH1 : CH0;
      else if (bus.ch1_valid_i)               gnt_ch = CH1;
      xfer   = gnt_any & ~fifo_full;
      win_d  = bus.ch0_window_i;
      kern_d = bus.kernel0_i;
      col_d  = bus.ch0_col_i;
      row_d  = bus.ch0_row_i;
      if (gnt_ch == CH1) begin
         win_d  = bus.ch1_window_i;
         kern_d = bus.kernel1_i;
         col_d  = bus.ch1_col_i;
         row_d  = bus.ch1_row_i;
      end
   end

   assign bus.ch0_ready_o = xfer & (gnt_ch == CH0);
   assign bus.ch1_ready_o = xfer & (gnt_ch == CH1);

   // Issue stage: register the granted request toward the datapath.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conv_valid_q <= 1'b0;
         win_q        <= '0;
         kern_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         last_grant_q <= CH1;
      end else begin
         conv_valid_q <= xfer;
         if (xfer) begin
            win_q        <= win_d;
            kern_q       <= kern_d;
            col_q        <= col_d;
            row_q        <= row_d;
            last_grant_q <= gnt_ch;
         end
      end
   end

   assign bus.conv_valid_o  = conv_valid_q;
   assign bus.conv_window_o = win_q;
   assign bus.conv_kernel_o = kern_q;
   assign bus.conv_col_o    = col_q;
   assign bus.conv_row_o    = row_q;

   assign tag_din = gnt_ch;
   assign tag_ch  = chan_t'(tag_dout);
   assign pop     = bus.conv_valid_i & ~fifo_empty;

   conv_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .W     (1)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (xfer),
      .pop_i   (pop),
      .din_i   (tag_din),
      .dout_o  (tag_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (tag_count_o)
   );

   // Return stage: send each result to the channel named by the head tag.
   // A result that arrives with no tag outstanding sets the sticky error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ch0_valid_q <= 1'b0;
         ch1_valid_q <= 1'b0;
         ch0_data_q  <= '0;
         ch1_data_q  <= '0;
         ch0_col_q   <= '0;
         ch0_row_q   <= '0;
         ch1_col_q   <= '0;
         ch1_row_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         ch0_valid_q <= pop & (tag_ch == CH0);
         ch1_valid_q <= pop & (tag_ch == CH1);
         if (pop && tag_ch == CH0) begin
            ch0_data_q <= bus.conv_data_i;
            ch0_col_q  <= bus.conv_col_i;
            ch0_row_q  <= bus.conv_row_i;
         end
         if (pop && tag_ch == CH1) begin
            ch1_data_q <= bus.conv_data_i;
            ch1_col_q  <= bus.conv_col_i;
            ch1_row_q  <= bus.conv_row_i;
         end
         if (bus.conv_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   assign bus.ch0_valid_o = ch0_valid_q;
   assign bus.ch1_valid_o = ch1_valid_q;
   assign bus.ch0_data_o  = ch0_data_q;
   assign bus.ch1_data_o  = ch1_data_q;
   assign bus.ch0_col_o   = ch0_col_q;
   assign bus.ch0_row_o   = ch0_row_q;
   assign bus.ch1_col_o   = ch1_col_q;
   assign bus.ch1_row_o   = ch1_row_q;
   assign err_o           = err_q;

`ifdef CONV_SHARE_ARB_PERF_EN
   logic [31:0] perf_g0_q, perf_g1_q, perf_st_q;

   // Performance counters. They wrap naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_g0_q <= '0;
         perf_g1_q <= '0;
         perf_st_q <= '0;
      end else begin
         if (xfer && gnt_ch == CH0) perf_g0_q <= perf_g0_q + 32'd1;
         if (xfer && gnt_ch == CH1) perf_g1_q <= perf_g1_q + 32'd1;
         if (gnt_any && fifo_full)  perf_st_q <= perf_st_q + 32'd1;
      end
   end

   assign perf_grant0_o = perf_g0_q;
   assign perf_grant1_o = perf_g1_q;
   assign perf_stall_o  = perf_st_q;
`endif
endmodule

// File: tb/tb_conv_share_arb_2ch.sv
// tb_conv_share_arb_2ch: directed bench for conv_share_arb_2ch.
// It uses two instances. dut has a 16-entry tag FIFO and a 5-stage datapath model.
// dut4 has a 4-entry tag FIFO and a datapath driven by hand, which exercises backpressure.
// When CONV_SHARE_ARB_PERF_EN is defined, the bench also checks the perf counters.
module tb_conv_share_arb_2ch;
   import conv_arb_pkg::*;

   localparam int EW = 5, FW = 10, WW = 1, WH = 3;
   localparam logic [47:0] K0 = {3{fp_word_t'(16'h3C00)}};
   localparam logic [47:0] K1 = {3{fp_word_t'(16'h3800)}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_share_arb_2ch_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)) bus ();
   conv_share_arb_2ch_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH)) bus4 ();

   logic       err, err4;
   logic [4:0] cnt;
   logic [2:0] cnt4;
`ifdef CONV_SHARE_ARB_PERF_EN
   logic [31:0] pg0, pg1, pst, pg0_4, pg1_4, pst_4;
`endif

   conv_share_arb_2ch #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW),
                        .WINDOW_HEIGHT(WH), .TAG_DEPTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .err_o(err), .tag_count_o(cnt)
`ifdef CONV_SHARE_ARB_PERF_EN
      , .perf_grant0_o(pg0), .perf_grant1_o(pg1), .perf_stall_o(pst)
`endif
   );

   conv_share_arb_2ch #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .WINDOW_WIDTH(WW),
                        .WINDOW_HEIGHT(WH), .TAG_DEPTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .bus(bus4), .err_o(err4), .tag_count_o(cnt4)
`ifdef CONV_SHARE_ARB_PERF_EN
      , .perf_grant0_o(pg0_4), .perf_grant1_o(pg1_4), .perf_stall_o(pst_4)
`endif
   );

   // Datapath model: a 5-stage delay. The result data is window element [0][0].
   logic        model_en = 1'b1;
   logic        man_v    = 1'b0;
   logic [4:0]  dp_v;
   logic [15:0] dp_col [5];
   logic [15:0] dp_row [5];
   logic [15:0] dp_dat [5];
   always @(posedge clk) begin
      if (rst) dp_v <= '0;
      else     dp_v <= {dp_v[3:0], bus.conv_valid_o};
      dp_col[0] <= bus.conv_col_o;
      dp_row[0] <= bus.conv_row_o;
      dp_dat[0] <= bus.conv_window_o[0][0];
      for (int i = 1; i < 5; i++) begin
         dp_col[i] <= dp_col[i-1];
         dp_row[i] <= dp_row[i-1];
         dp_dat[i] <= dp_dat[i-1];
      end
   end
   assign bus.conv_valid_i = model_en ? dp_v[4] : man_v;
   assign bus.conv_col_i   = dp_col[4];
   assign bus.conv_row_i   = dp_row[4];
   assign bus.conv_data_i  = dp_dat[4];

   // Result capture: each entry is {data, row, col}.
   logic [47:0] q0 [$];
   logic [47:0] q1 [$];
   always @(negedge clk) begin
      if (bus.ch0_valid_o) q0.push_back({bus.ch0_data_o, bus.ch0_row_o, bus.ch0_col_o});
      if (bus.ch1_valid_o) q1.push_back({bus.ch1_data_o, bus.ch1_row_o, bus.ch1_col_o});
   end

   int ntests = 0;
   int nfail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   initial begin
      int n0, n1, g, pg;
      logic [15:0] pcol;

      bus.ch0_valid_i = 0;  bus.ch1_valid_i = 0;
      bus.ch0_window_i = '0; bus.ch1_window_i = '0;
      bus.ch0_col_i = 0; bus.ch0_row_i = 0; bus.ch1_col_i = 0; bus.ch1_row_i = 0;
      bus.kernel0_i = K0; bus.kernel1_i = K1;
      bus4.ch0_valid_i = 0; bus4.ch1_valid_i = 0;
      bus4.ch0_window_i = '0; bus4.ch1_window_i = '0;
      bus4.ch0_col_i = 16'd1; bus4.ch0_row_i = 0; bus4.ch1_col_i = 16'd2; bus4.ch1_row_i = 0;
      bus4.kernel0_i = K0; bus4.kernel1_i = K1;
      bus4.conv_valid_i = 0; bus4.conv_data_i = 0; bus4.conv_col_i = 0; bus4.conv_row_i = 0;

      // Reset state.
      step();
      step();
      check("rst_conv_valid", 64'(bus.conv_valid_o), 64'd0);
      check("rst_conv_col",   64'(bus.conv_col_o), 64'd0);
      check("rst_conv_kernel", 64'(bus.conv_kernel_o), 64'd0);
      check("rst_ch0_valid",  64'(bus.ch0_valid_o), 64'd0);
      check("rst_ch1_valid",  64'(bus.ch1_valid_o), 64'd0);
      check("rst_ch0_data",   64'(bus.ch0_data_o), 64'd0);
      check("rst_err",        64'(err), 64'd0);
      check("rst_count",      64'(cnt), 64'd0);
      check("rst_count4",     64'(cnt4), 64'd0);
      rst = 1'b0;

      // Single channel: ch0 sends cols 0..3 while ch1 is idle.
      for (int k = 0; k < 4; k++) begin
         step();
         bus.ch0_valid_i  = 1'b1;
         bus.ch0_col_i    = 16'(k);
         bus.ch0_row_i    = 16'(10 + k);
         bus.ch0_window_i = 48'(16'h100 + k);
         @(negedge clk);
         check("single_ready0", 64'(bus.ch0_ready_o), 64'd1);
         check("single_ready1", 64'(bus.ch1_ready_o), 64'd0);
         if (k > 0) begin
            check("single_issue_v", 64'(bus.conv_valid_o), 64'd1);
            check("single_issue_col", 64'(bus.conv_col_o), 64'(k - 1));
            check("single_issue_kern", 64'(bus.conv_kernel_o), 64'(K0));
         end
      end
      step();
      bus.ch0_valid_i = 1'b0;
      @(negedge clk);
      check("single_last_col", 64'(bus.conv_col_o), 64'd3);
      check("single_last_v",   64'(bus.conv_valid_o), 64'd1);
      step();
      @(negedge clk);
      check("single_idle_v", 64'(bus.conv_valid_o), 64'd0);
      repeat (12) step();
      check("single_q0_size", 64'(q0.size()), 64'd4);
      check("single_q1_size", 64'(q1.size()), 64'd0);
      for (int k = 0; k < 4 && k < q0.size(); k++)
         check("single_q0_entry", 64'(q0[k]), 64'({16'(16'h100 + k), 16'(10 + k), 16'(k)}));
      check("single_count_drained", 64'(cnt), 64'd0);
      check("single_err", 64'(err), 64'd0);

      // Contention: both channels stay valid for 8 grants.
      do_reset();
      n0 = 0; n1 = 0; pg = 0; pcol = 0;
      bus.ch0_valid_i = 1'b1; bus.ch1_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.ch0_col_i = 16'(20 + n0); bus.ch0_row_i = 16'(100 + n0); bus.ch0_window_i = 48'(16'h200 + n0);
         bus.ch1_col_i = 16'(40 + n1); bus.ch1_row_i = 16'(120 + n1); bus.ch1_window_i = 48'(16'h300 + n1);
         g = i % 2;
         @(negedge clk);
         check("cont_ready0", 64'(bus.ch0_ready_o), 64'(g == 0));
         check("cont_ready1", 64'(bus.ch1_ready_o), 64'(g == 1));
         if (i > 0) begin
            check("cont_issue_kern", 64'(bus.conv_kernel_o), (pg == 1) ? 64'(K1) : 64'(K0));
            check("cont_issue_col",  64'(bus.conv_col_o), 64'(pcol));
         end
         pcol = (g == 0) ? 16'(20 + n0) : 16'(40 + n1);
         pg = g;
         step();
         if (g == 0) n0++; else n1++;
      end
      bus.ch0_valid_i = 1'b0; bus.ch1_valid_i = 1'b0;
      @(negedge clk);
      check("cont_last_kern", 64'(bus.conv_kernel_o), 64'(K1));
      check("cont_last_col",  64'(bus.conv_col_o), 64'd43);
`ifdef CONV_SHARE_ARB_PERF_EN
      check("perf_grant0", 64'(pg0), 64'd4);
      check("perf_grant1", 64'(pg1), 64'd4);
      check("perf_stall",  64'(pst), 64'd0);
`endif
      repeat (12) step();
      check("cont_q0_size", 64'(q0.size()), 64'd4);
      check("cont_q1_size", 64'(q1.size()), 64'd4);
      for (int k = 0; k < 4 && k < q0.size(); k++)
         check("cont_q0_entry", 64'(q0[k]), 64'({16'(16'h200 + k), 16'(100 + k), 16'(20 + k)}));
      for (int k = 0; k < 4 && k < q1.size(); k++)
         check("cont_q1_entry", 64'(q1[k]), 64'({16'(16'h300 + k), 16'(120 + k), 16'(40 + k)}));

      // Error: a result pulse arrives while the FIFO is empty.
      do_reset();
      model_en = 1'b0;
      step();
      man_v = 1'b1;
      step();
      man_v = 1'b0;
      @(negedge clk);
      check("err_set",    64'(err), 64'd1);
      check("err_ch0_v",  64'(bus.ch0_valid_o), 64'd0);
      check("err_ch1_v",  64'(bus.ch1_valid_o), 64'd0);
      check("err_count",  64'(cnt), 64'd0);
      repeat (3) step();
      check("err_sticky", 64'(err), 64'd1);
      check("err_no_route", 64'(q0.size() + q1.size()), 64'd0);
      model_en = 1'b1;
      do_reset();
      check("err_cleared", 64'(err), 64'd0);

      // Reset mid-stream, with 3 tags in flight.
      bus.ch0_valid_i = 1'b1; bus.ch0_col_i = 16'd5; bus.ch0_row_i = 16'd6; bus.ch0_window_i = 48'h7;
      repeat (3) step();
      check("mid_count3", 64'(cnt), 64'd3);
      bus.ch0_valid_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_conv_v",   64'(bus.conv_valid_o), 64'd0);
      check("mid_conv_col", 64'(bus.conv_col_o), 64'd0);
      check("mid_conv_win", 64'(bus.conv_window_o), 64'd0);
      check("mid_ch0_v",    64'(bus.ch0_valid_o), 64'd0);
      check("mid_ch1_v",    64'(bus.ch1_valid_o), 64'd0);
      check("mid_count",    64'(cnt), 64'd0);
      check("mid_err",      64'(err), 64'd0);
      bus.ch0_valid_i = 1'b1; bus.ch1_valid_i = 1'b1;
      @(negedge clk);
      check("mid_rr_ready0", 64'(bus.ch0_ready_o), 64'd1);
      check("mid_rr_ready1", 64'(bus.ch1_ready_o), 64'd0);
      step();
      bus.ch0_valid_i = 1'b0; bus.ch1_valid_i = 1'b0;
      repeat (10) step();
      check("mid_err_after", 64'(err), 64'd0);
      check("mid_q0_size", 64'(q0.size()), 64'd1);

      // Backpressure on the 4-deep instance.
      do_reset();
      bus4.ch0_valid_i = 1'b1; bus4.ch1_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_ready0", 64'(bus4.ch0_ready_o), 64'(i % 2 == 0));
         check("bp_ready1", 64'(bus4.ch1_ready_o), 64'(i % 2 == 1));
         step();
      end
      @(negedge clk);
      check("bp_full_count",  64'(cnt4), 64'd4);
      check("bp_full_ready0", 64'(bus4.ch0_ready_o), 64'd0);
      check("bp_full_ready1", 64'(bus4.ch1_ready_o), 64'd0);
      step();
      bus4.conv_valid_i = 1'b1; bus4.conv_col_i = 16'd77; bus4.conv_data_i = 16'hABCD;
      @(negedge clk);
      check("bp_pop_ready0", 64'(bus4.ch0_ready_o), 64'd0);
      check("bp_pop_ready1", 64'(bus4.ch1_ready_o), 64'd0);
      step();
      bus4.conv_valid_i = 1'b0;
      @(negedge clk);
      check("bp_free_count",  64'(cnt4), 64'd3);
      check("bp_free_ready0", 64'(bus4.ch0_ready_o), 64'd1);
      check("bp_free_ready1", 64'(bus4.ch1_ready_o), 64'd0);
      check("bp_ret_v0",   64'(bus4.ch0_valid_o), 64'd1);
      check("bp_ret_v1",   64'(bus4.ch1_valid_o), 64'd0);
      check("bp_ret_col",  64'(bus4.ch0_col_o), 64'd77);
      check("bp_ret_data", 64'(bus4.ch0_data_o), 64'hABCD);
      step();
      @(negedge clk);
      check("bp_refull_count",  64'(cnt4), 64'd4);
      check("bp_refull_ready0", 64'(bus4.ch0_ready_o), 64'd0);
      check("bp_refull_ready1", 64'(bus4.ch1_ready_o), 64'd0);
      check("bp_err4", 64'(err4), 64'd0);
      bus4.ch0_valid_i = 1'b0; bus4.ch1_valid_i = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/conv_share_arb_2ch.md
Name: conv_share_arb_2ch

Overview:
- Time-multiplexes one convolution_floating_point instance (for example a 1x3 box kernel) between two pixel-window requesters, ch0 and ch1.
- Round-robin arbitration selects which window and kernel are issued each cycle.
- A tag FIFO tracks result ownership, so each result returns only to its originating channel.
- Sits between the two line-buffer/window generators of the dfdd pipeline and the single shared convolution datapath.

Parameters:
- EXP_WIDTH, 5, float exponent width.
- FRAC_WIDTH, 10, float fraction width.
- WINDOW_WIDTH, 1, window columns.
- WINDOW_HEIGHT, 3, window rows.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, float word width (local).
- TAG_DEPTH, 16, tag FIFO entries; must be ≥ convolution latency + 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- chN_window_i  in  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  window from requester N (N=0,1).
- chN_col_i / chN_row_i  in  16  pixel coordinates.
- chN_valid_i  in  1  request valid.
- chN_ready_o  out  1  request accepted this cycle when valid&ready.
- kernelN_i  in  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  kernel coefficients used for channel N.
- conv_window_o / conv_kernel_o  out  FP_WIDTH_REG [..][..]  to datapath.
- conv_col_o / conv_row_o  out  16  to datapath.
- conv_valid_o  out  1  to datapath.
- conv_data_i  in  FP_WIDTH_REG  result from datapath.
- conv_col_i / conv_row_i  in  16  result coordinates.
- conv_valid_i  in  1  result valid.
- chN_data_o  out  FP_WIDTH_REG  routed result.
- chN_col_o / chN_row_o  out  16  routed coordinates.
- chN_valid_o  out  1  routed result valid.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - All registered outputs go to 0: conv_*_o, chN_*_o, err_o.
  - Tag FIFO empties.
  - last_grant := 1, so ch0 wins the first contention.
- Arbitration (combinational, per cycle):
  - Only chN_valid_i high → grant N.
  - Both high → grant !last_grant.
  - Neither → no grant.
- Handshake:
  - chN_ready_o = (grant==N) & !fifo_full.
  - ready depends on the valid inputs; the valid inputs must not depend on ready.
  - A transfer occurs when chN_valid_i & chN_ready_o; on a transfer, last_grant := N.
- Issue stage (registered, latency 1 cycle from accept):
  - conv_valid_o := transfer.
  - conv_window_o / col / row := granted channel's inputs.
  - conv_kernel_o := kernelN_i of the granted channel.
  - When there is no transfer, conv_valid_o := 0 and the data registers hold their previous values.
- Tag FIFO (1-bit tags, TAG_DEPTH entries, in-order):
  - Push the granted channel id on transfer; pop on conv_valid_i.
  - Simultaneous push and pop is legal, including when full (pop frees the slot that cycle only if ready logic uses a registered full; full is computed from the registered count, so ready stays low when full even if a pop happens the same cycle).
- Return routing (registered, latency 1 cycle from conv_valid_i):
  - tag==N → chN_valid_o := 1, chN_data_o / col / row := conv_*_i.
  - The other channel's valid := 0; its data holds.
- Boundary conditions:
  - conv_valid_i with FIFO empty: err_o := 1 (sticky until reset), no chN_valid_o asserted, count stays 0.
  - Push when full cannot occur (ready gated).
  - Count wraps never; pointers wrap modulo TAG_DEPTH.
- Reset mid-operation: in-flight tags are discarded. Results arriving after reset with an empty FIFO set err_o, so the datapath must be reset together with this block.
- Throughput: one issue per cycle sustained. With both channels continuously valid, grants alternate 0,1,0,1...

Optional Feature:
- Macro: CONV_SHARE_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant0_o, perf_grant1_o (32-bit transfer counts per channel) and perf_stall_o (32-bit count of cycles with any chN_valid_i high, no transfer, and FIFO full).
  - All counters clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package conv_arb_pkg:
  - chan_t (1-bit enum CH0/CH1).
  - function tag_cnt_width(depth) = $clog2(depth+1).
  - typedef for FP word, parameterised by widths, via the package parameters EXP_WIDTH / FRAC_WIDTH defaults.
- Sub-module conv_arb_tag_fifo:
  - Parameterised depth/width, synchronous active-high reset.
  - Interface: push/pop/din/dout/full/empty/count.

Test Plan:
- Single channel: ch0 valid for 4 cycles with col 0..3, ch1 idle → conv_valid_o high cycles 1-4, conv_kernel_o = kernel0_i; results returned via a 5-cycle delay model appear only on ch0_valid_o with col 0..3 in order.
- Contention: both channels continuously valid for 8 cycles from reset → grants 0,1,0,1,0,1,0,1; each channel gets 4 results with matching col/row; conv_kernel_o alternates kernel0_i / kernel1_i.
- Backpressure: TAG_DEPTH=4 with the datapath model withholding results → both ready_o low after 4 transfers; releasing one result re-enables exactly one transfer the following cycle.
- Error: conv_valid_i pulse with the FIFO empty → err_o = 1 next cycle and stays 1; ch0_valid_o and ch1_valid_o stay 0; rst_i clears err_o.
- Reset mid-stream: assert rst_i with 3 tags in flight → next cycle all outputs 0, count 0, and ch0 wins the next contention.
- With CONV_SHARE_ARB_PERF_EN defined, run the contention scenario → perf_grant0_o = 4, perf_grant1_o = 4, perf_stall_o = 0.
